// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared state encoding, frame constants and the parity helper
//               for the PS/2 device-to-host receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Receiver FSM state encoding
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    // Payload bits carried in one PS/2 frame
    localparam int PS2_DATA_BITS = 8;

    // True when the data byte plus its parity bit hold an odd number of ones
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic p);
        return ^{data, p};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
// Module      : ps2_line_filter
// Description : Two-flop synchronizer followed by a run-length deglitcher.
//               The output follows the input only after FILTER_LEN
//               consecutive synchronized samples disagree with it.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_filt
);

    // Run length at which the filtered value flips
    localparam logic [3:0] c_RUN_LAST = 4'(FILTER_LEN - 1);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_filt;
    logic [3:0] r_run;

    // Synchronize the asynchronous line; idle PS/2 bus is high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive disagreeing samples; any agreeing sample restarts the run
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt <= 1'b1;
            r_run  <= 4'd0;
        end else if (r_sync2 != r_filt) begin
            if (r_run == c_RUN_LAST) begin
                r_filt <= r_sync2;
                r_run  <= 4'd0;
            end else begin
                r_run <= r_run + 4'd1;
            end
        end else begin
            r_run <= 4'd0;
        end
    end

    assign o_filt = r_filt;

endmodule
`default_nettype wire

// File: rtl/ps2_receiver.sv
`default_nettype none
// ============================================================================
// Module      : ps2_receiver
// Description : PS/2 device-to-host deserializer. Samples the filtered data
//               line on filtered clock falling edges, checks start/parity/
//               stop, and presents each good scan code with a one-cycle
//               strobe. Bad frames and stalled frames raise error strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       PS2_CLOCK,
    input  logic       PS2_DATA,
    output logic [7:0] keycode,
    output logic       is_pressed,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int                c_TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]        c_BIT_LAST = 4'(PS2_DATA_BITS - 1);

    logic w_clk_filt;
    logic w_dat_filt;
    logic w_fall;
    logic r_clk_prev;

    logic [1:0]        r_state,      w_state_next;
    logic [3:0]        r_bit_cnt,    w_bit_cnt_next;
    logic [7:0]        r_shreg,      w_shreg_next;
    logic              r_parity,     w_parity_next;
    logic [c_TO_W-1:0] r_to_cnt,     w_to_cnt_next;
    logic [7:0]        r_keycode,    w_keycode_next;
    logic              r_is_pressed, w_is_pressed_next;
    logic              r_parity_err, w_parity_err_next;
    logic              r_frame_err,  w_frame_err_next;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (PS2_CLOCK),
        .o_filt (w_clk_filt)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (PS2_DATA),
        .o_filt (w_dat_filt)
    );

    // Remember the filtered clock to detect its falling edge
    always_ff @(posedge clk) begin
        if (rst) r_clk_prev <= 1'b1;
        else     r_clk_prev <= w_clk_filt;
    end

    assign w_fall = r_clk_prev & ~w_clk_filt;

    // State, datapath and registered strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_bit_cnt    <= 4'd0;
            r_shreg      <= 8'h00;
            r_parity     <= 1'b0;
            r_to_cnt     <= '0;
            r_keycode    <= 8'h00;
            r_is_pressed <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_shreg      <= w_shreg_next;
            r_parity     <= w_parity_next;
            r_to_cnt     <= w_to_cnt_next;
            r_keycode    <= w_keycode_next;
            r_is_pressed <= w_is_pressed_next;
            r_parity_err <= w_parity_err_next;
            r_frame_err  <= w_frame_err_next;
        end
    end

    // Next-state, bit capture, frame verdict and inter-edge timeout
    always_comb begin
        w_state_next      = r_state;
        w_bit_cnt_next    = r_bit_cnt;
        w_shreg_next      = r_shreg;
        w_parity_next     = r_parity;
        w_to_cnt_next     = r_to_cnt;
        w_keycode_next    = r_keycode;
        w_is_pressed_next = 1'b0;
        w_parity_err_next = 1'b0;
        w_frame_err_next  = 1'b0;

        if (r_state == IDLE) begin
            w_to_cnt_next = '0;
            // A high start bit is a spurious edge and is silently ignored
            if (w_fall && !w_dat_filt) begin
                w_state_next   = DATA;
                w_bit_cnt_next = 4'd0;
            end
        end else if (w_fall) begin
            // An edge always wins over a coincident timeout
            w_to_cnt_next = '0;
            case (r_state)
                DATA: begin
                    w_shreg_next   = {w_dat_filt, r_shreg[7:1]};
                    w_bit_cnt_next = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == c_BIT_LAST) w_state_next = PARITY;
                end
                PARITY: begin
                    w_parity_next = w_dat_filt;
                    w_state_next  = STOP;
                end
                STOP: begin
                    w_state_next = IDLE;
                    if (!w_dat_filt) begin
                        w_frame_err_next = 1'b1;
                    end else if (!odd_parity_ok(r_shreg, r_parity)) begin
                        w_parity_err_next = 1'b1;
                    end else begin
                        w_keycode_next    = r_shreg;
                        w_is_pressed_next = 1'b1;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end else if (r_to_cnt == c_TO_LAST) begin
            // Device stalled mid-frame: drop the partial byte
            w_frame_err_next = 1'b1;
            w_state_next     = IDLE;
            w_to_cnt_next    = '0;
            w_bit_cnt_next   = 4'd0;
            w_shreg_next     = 8'h00;
        end else begin
            w_to_cnt_next = r_to_cnt + 1'b1;
        end
    end

    assign keycode    = r_keycode;
    assign is_pressed = r_is_pressed;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ps2_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_receiver
// Description : Directed, table-driven bench for ps2_receiver with
//               hand-written sequences for timeout, glitch and reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] keycode;
    logic       is_pressed;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    ps2_receiver #(.FILTER_LEN(4), .TIMEOUT_CYCLES(2000)) dut (
        .clk        (clk),
        .rst        (rst),
        .PS2_CLOCK  (ps2_clk),
        .PS2_DATA   (ps2_dat),
        .keycode    (keycode),
        .is_pressed (is_pressed),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Posedge counter used as the time base for latency checks
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: running totals plus the posedge that produced the last strobe
    int n_press = 0, n_perr = 0, n_ferr = 0, t_strobe = 0;
    always @(negedge clk) begin
        if (is_pressed) begin n_press++; t_strobe = cyc; end
        if (parity_err) begin n_perr++;  t_strobe = cyc; end
        if (frame_err)  begin n_ferr++;  t_strobe = cyc; end
    end

    int n_vec = 0, n_bad = 0;
    int t_fall = 0;
    int b_press, b_perr, b_ferr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        b_press = n_press; b_perr = n_perr; b_ferr = n_ferr;
    endtask

    // Frame bit i is fr[i]; data changes mid-high, glitch optional before a bit's fall
    task automatic send_frame(input logic [10:0] fr, input int nbits, input int glitch_bit);
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = fr[i];
            if (i == glitch_bit) begin
                wait_cyc(20);
                ps2_clk = 1'b0;
                wait_cyc(3);
                ps2_clk = 1'b1;
                wait_cyc(27);
            end else begin
                wait_cyc(50);
            end
            ps2_clk = 1'b0;
            t_fall  = cyc + 1;   // first posedge that samples this raw edge
            wait_cyc(100);
            if (i == 0) check("busy_after_start", 32'(busy), 32'd1);
            ps2_clk = 1'b1;
            wait_cyc(50);
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         press;
        int         perr;
        int         ferr;
        logic [7:0] key;
    } vec_t;

    vec_t vecs[5];

    initial begin
        // name, data, parity, stop, is_pressed, parity_err, frame_err, keycode after
        vecs[0] = '{"good_1c",   8'h1C, 1'b0, 1'b1, 1, 0, 0, 8'h1C};
        vecs[1] = '{"good_f0",   8'hF0, 1'b1, 1'b1, 1, 0, 0, 8'hF0};
        vecs[2] = '{"good_1c_b", 8'h1C, 1'b0, 1'b1, 1, 0, 0, 8'h1C};
        vecs[3] = '{"bad_par",   8'h1C, 1'b1, 1'b1, 0, 1, 0, 8'h1C};
        vecs[4] = '{"bad_stop",  8'h29, 1'b0, 1'b0, 0, 0, 1, 8'h1C};

        rst = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1;
        wait_cyc(5);
        rst = 1'b0;
        wait_cyc(1);
        check("reset_keycode", 32'(keycode), 32'h00);
        check("reset_strobes", {29'd0, is_pressed, parity_err, frame_err}, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        // Table-driven frames, 300 cycles of idle between them
        for (int v = 0; v < 5; v++) begin
            snap();
            send_frame(mk(vecs[v].data, vecs[v].par, vecs[v].stop), 11, -1);
            wait_cyc(250);
            check({vecs[v].name, "_press"}, 32'(n_press - b_press), 32'(vecs[v].press));
            check({vecs[v].name, "_perr"},  32'(n_perr - b_perr),   32'(vecs[v].perr));
            check({vecs[v].name, "_ferr"},  32'(n_ferr - b_ferr),   32'(vecs[v].ferr));
            check({vecs[v].name, "_key"},   32'(keycode),           32'(vecs[v].key));
            check({vecs[v].name, "_latency"}, 32'(t_strobe), 32'(t_fall + 6));
            check({vecs[v].name, "_busy_end"}, 32'(busy), 32'd0);
        end

        // Stalled frame: start + 5 data bits, then clock held high
        snap();
        send_frame(mk(8'h29, 1'b0, 1'b1), 6, -1);
        for (int k = 0; k < 2500 && n_ferr == b_ferr; k++) wait_cyc(1);
        check("timeout_seen", 32'(n_ferr - b_ferr), 32'd1);
        check("timeout_at", 32'(t_strobe), 32'(t_fall + 2006));
        wait_cyc(2);
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_key", 32'(keycode), 32'h1C);
        check("timeout_press", 32'(n_press - b_press), 32'd0);
        wait_cyc(300);
        snap();
        send_frame(mk(8'h29, 1'b0, 1'b1), 11, -1);
        wait_cyc(250);
        check("after_to_key", 32'(keycode), 32'h29);
        check("after_to_press", 32'(n_press - b_press), 32'd1);

        // Short glitch on an idle bus
        snap();
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(50);
        check("idle_glitch_busy", 32'(busy), 32'd0);
        check("idle_glitch_strobes", 32'((n_press - b_press) + (n_perr - b_perr) + (n_ferr - b_ferr)), 32'd0);

        // Short glitch inside a frame
        snap();
        send_frame(mk(8'h1C, 1'b0, 1'b1), 11, 4);
        wait_cyc(250);
        check("glitch_frame_key", 32'(keycode), 32'h1C);
        check("glitch_frame_press", 32'(n_press - b_press), 32'd1);
        check("glitch_frame_err", 32'((n_perr - b_perr) + (n_ferr - b_ferr)), 32'd0);

        // Reset mid-frame after bit 4
        snap();
        send_frame(mk(8'h5A, 1'b1, 1'b1), 5, -1);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        check("rst_keycode", 32'(keycode), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_strobes", {29'd0, is_pressed, parity_err, frame_err}, 32'd0);
        wait_cyc(2500);
        check("rst_no_strobe", 32'((n_press - b_press) + (n_perr - b_perr) + (n_ferr - b_ferr)), 32'd0);
        snap();
        send_frame(mk(8'h5A, 1'b1, 1'b1), 11, -1);
        wait_cyc(250);
        check("after_rst_key", 32'(keycode), 32'h5A);
        check("after_rst_press", 32'(n_press - b_press), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
